// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcodes, class and state encodings shared by the encoder, its decoder and the bench.
package instr_encoder_pkg;
   localparam int DEPTH = 32;
   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_SLTI = 6'd10;
   typedef enum logic [1:0] {CLS_R, CLS_BEQ, CLS_ADDI, CLS_SLTI} cls_e;
   typedef enum logic [1:0] {IDLE, WRITE, DONE, FULL} state_e;
   function automatic logic [5:0] opcode_of(cls_e c);
      return c == CLS_BEQ ? OP_BEQ : c == CLS_ADDI ? OP_ADDI : c == CLS_SLTI ? OP_SLTI : OP_R;
   endfunction
endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack: packs an instruction class and its fields into a 32-bit MIPS-style word.
module instr_word_pack
   import instr_encoder_pkg::*;
(
   input  cls_e        cls,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   output logic [31:0] word
);
   always_comb word = cls == CLS_R ? {OP_R, rs, rt, rd, 5'd0, funct} : {opcode_of(cls), rs, rt, imm};
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction requests, encodes them and writes them sequentially
// into instruction memory, stopping on the last instruction or when memory is full.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  class_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  funct_i,
   input  logic [15:0] imm_i,
   input  logic        last_i,
   output logic        im_we_o,
   output logic [31:0] im_addr_o,
   output logic [31:0] im_data_o,
   output logic [5:0]  count_o,
   output logic        full_o,
   output logic        done_o
);
   state_e      state;
   logic        last_q;
   logic        accept;
   logic [31:0] word;

   instr_word_pack u_pack (
      .cls   (cls_e'(class_i)),
      .rs    (rs_i),
      .rt    (rt_i),
      .rd    (rd_i),
      .funct (funct_i),
      .imm   (imm_i),
      .word  (word)
   );

   assign accept = req_valid_i && req_ready_o && !clear_i;

   always_comb begin
      req_ready_o = state == IDLE;
      full_o      = state == FULL;
      done_o      = state == DONE;
   end

   // The write bus is registered at acceptance, so the WRITE cycle is exactly the im_we_o cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         count_o   <= '0;
         last_q    <= 1'b0;
         im_we_o   <= 1'b0;
         im_addr_o <= '0;
         im_data_o <= '0;
      end else begin
         im_we_o   <= accept;
         im_data_o <= accept ? word : '0;
         im_addr_o <= accept ? {24'd0, count_o, 2'b00} : '0;
         if (accept) last_q <= last_i;
         if (clear_i) begin
            state   <= IDLE;
            count_o <= '0;
         end else if (state == IDLE) begin
            state <= accept ? WRITE : IDLE;
         end else if (state == WRITE) begin
            count_o <= count_o == 6'(DEPTH) ? count_o : count_o + 6'd1;
            state   <= last_q ? DONE : count_o == 6'(DEPTH - 1) ? FULL : IDLE;
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven and sequence checks of instr_encoder against a write scoreboard.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst, clear, valid, ready, last, we, full, done;
   logic [1:0]  cls;
   logic [4:0]  rs, rt, rd;
   logic [5:0]  funct, count;
   logic [15:0] imm;
   logic [31:0] addr, data;
   logic        mon_en = 1'b0;
   int          checks = 0, failures = 0, mcount = 0;
   logic [63:0] sb[$];

   typedef struct {
      logic [1:0]  c;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  f;
      logic [15:0] imm;
      logic [31:0] w;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_valid_i(valid), .req_ready_o(ready),
      .class_i(cls), .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .imm_i(imm),
      .last_i(last), .im_we_o(we), .im_addr_o(addr), .im_data_o(data),
      .count_o(count), .full_o(full), .done_o(done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [1:0] c, input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] im);
      case (c)
         2'd0:    return {6'd0, s, t, d, 5'd0, f};
         2'd1:    return {6'd4, s, t, im};
         2'd2:    return {6'd8, s, t, im};
         default: return {6'd10, s, t, im};
      endcase
   endfunction

   always @(negedge clk) begin : mon
      logic [63:0] e;
      if (mon_en) begin
         if (we === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr, data);
            end else begin
               e = sb.pop_front();
               chk("write_addr", addr, e[63:32]);
               chk("write_data", data, e[31:0]);
            end
         end else begin
            chk("idle_bus", addr | data, 32'd0);
         end
      end
   end

   task automatic send(input logic [1:0] c, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [5:0] f, input logic [15:0] im, input logic l, input logic [31:0] w);
      cls = c; rs = s; rt = t; rd = d; funct = f; imm = im; last = l; valid = 1'b1;
      chk("ready_before_req", 32'(ready), 32'd1);
      sb.push_back({32'(mcount * 4), w});
      @(posedge clk); #1 valid = 1'b0; last = 1'b0;
      @(posedge clk); #1;
      if (mcount < 32) mcount++;
      chk("count", 32'(count), 32'(mcount));
   endtask

   task automatic burst(input int n, input logic l_final);
      for (int i = 0; i < n; i++) begin
         logic [1:0]  c;
         logic [4:0]  s, t, d;
         logic [5:0]  f;
         logic [15:0] im;
         c = 2'($urandom_range(0, 3)); s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
         f = 6'($urandom); im = 16'($urandom);
         send(c, s, t, d, f, im, l_final && i == n - 1, enc(c, s, t, d, f, im));
      end
   endtask

   task automatic reject(input int n);
      valid = 1'b1;
      repeat (n) begin
         chk("ready_blocked", 32'(ready), 32'd0);
         @(posedge clk); #1;
      end
      valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      mcount = 0;
      chk("clear_count", 32'(count), 32'd0);
      chk("clear_ready", 32'(ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clear = 1'b0; valid = 1'b0; last = 1'b0;
      cls = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0;
      tbl[0] = '{2'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 32'h00221820};
      tbl[1] = '{2'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'h03FFF83F};
      tbl[2] = '{2'd2, 5'd0,  5'd0,  5'd7,  6'h3F, 16'h8000, 32'h20008000};
      tbl[3] = '{2'd3, 5'd31, 5'd0,  5'd1,  6'h01, 16'h1234, 32'h2BE01234};
      tbl[4] = '{2'd1, 5'd0,  5'd31, 5'd0,  6'h00, 16'h0000, 32'h101F0000};
      tbl[5] = '{2'd3, 5'd1,  5'd2,  5'd0,  6'h00, 16'h0007, 32'h28220007};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; mon_en = 1'b1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      for (int i = 0; i < 6; i++)
         send(tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].f, tbl[i].imm, 1'b0, tbl[i].w);

      do_clear();
      send(2'd2, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0005, 1'b0, 32'h21090005);
      send(2'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 1'b0, 32'h1022FFFF);
      send(2'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0007, 1'b1, 32'h28220007);
      chk("last_done", 32'(done), 32'd1);
      chk("last_full", 32'(full), 32'd0);
      reject(4);
      chk("done_count_held", 32'(count), 32'd3);
      chk("done_held", 32'(done), 32'd1);

      do_clear();
      chk("clear_done", 32'(done), 32'd0);
      send(2'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 1'b0, 32'h00221820);
      valid = 1'b1; clear = 1'b1;
      @(posedge clk); #1 valid = 1'b0; clear = 1'b0;
      mcount = 0;
      chk("clear_blocks_req_count", 32'(count), 32'd0);
      chk("clear_blocks_req_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;

      burst(32, 1'b0);
      chk("full_full", 32'(full), 32'd1);
      chk("full_done", 32'(done), 32'd0);
      chk("full_count", 32'(count), 32'd32);
      reject(3);
      chk("full_count_held", 32'(count), 32'd32);

      do_clear();
      burst(5, 1'b0);
      cls = 2'd2; rs = 5'd4; rt = 5'd5; imm = 16'h00AB; valid = 1'b1;
      sb.push_back({32'h14, enc(2'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'h00AB)});
      @(posedge clk); #1 valid = 1'b0; clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      mcount = 0;
      chk("clear_in_write_count", 32'(count), 32'd0);
      chk("clear_in_write_ready", 32'(ready), 32'd1);
      burst(1, 1'b0);

      cls = 2'd0; rs = 5'd3; valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1 valid = 1'b0; rst = 1'b0;
      mcount = 0;
      chk("rst_accept_we", 32'(we), 32'd0);
      chk("rst_accept_count", 32'(count), 32'd0);
      chk("rst_accept_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;

      burst(32, 1'b1);
      chk("done_prio_done", 32'(done), 32'd1);
      chk("done_prio_full", 32'(full), 32'd0);
      chk("done_prio_count", 32'(count), 32'd32);

      @(posedge clk); #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: clear_i  in  1  synchronous restart of the write pointer; no data is erased.
REQ-004 SHALL have ports: req_valid_i  in  1 / req_ready_o  out  1  request handshake.
REQ-005 SHALL have ports: class_i  in  2  instruction class: 00 R-type, 01 beq, 10 addi, 11 slti.
REQ-006 SHALL have ports: rs_i  in  5 / rt_i  in  5 / rd_i  in  5 / funct_i  in  6 / imm_i  in  16  instruction fields.
REQ-007 SHALL have ports: last_i  in  1  marks the final instruction of a program.
REQ-008 SHALL have ports: im_we_o  out  1 / im_addr_o  out  32 (byte address) / im_data_o  out  32  instruction-memory write port.
REQ-009 SHALL have ports: count_o  out  6  words written; full_o  out  1; done_o  out  1.

Function
REQ-010 SHALL accept a request only in a cycle where req_valid_i && req_ready_o && !clear_i.
REQ-011 SHALL encode R-type as {6'd0, rs, rt, rd, 5'd0, funct}, and beq/addi/slti as {opcode, rs, rt, imm}, with opcode 4/8/10 respectively; fields not used by the class are ignored.
REQ-012 SHALL register the encoded word and present it with im_we_o=1 for exactly one cycle, in the cycle after acceptance (latency 1).
REQ-013 SHALL drive im_addr_o = 4*count_o during the write cycle, and SHALL increment count_o by 1 at the end of that cycle.
REQ-014 SHALL implement a state machine with states IDLE, WRITE, DONE and FULL.
REQ-015 SHALL hold req_ready_o=1 only in IDLE.
REQ-016 SHALL transition IDLE->WRITE on acceptance.
REQ-017 SHALL transition out of WRITE as follows: to DONE if the captured last_i=1; else to FULL if the write filled word 31; else back to IDLE.
REQ-018 SHALL assert done_o in DONE and full_o in FULL, with req_ready_o=0 in both.
REQ-019 SHALL leave DONE and FULL only via clear_i or rst_i.
REQ-020 SHALL make count_o saturate at 32; the address SHALL never wrap to 0 without clear_i.
REQ-021 SHALL, on clear_i in any state, enter IDLE with count_o=0 on the next edge.
REQ-022 SHALL, if clear_i is asserted during WRITE, still complete the pending write; the count increment is discarded and clear takes priority.
REQ-023 SHALL ignore req_valid_i when clear_i=1 in the same cycle; no acceptance occurs.
REQ-024 SHALL, when last_i=1 and the write fills word 31 in the same request, enter DONE; DONE has priority over FULL.
REQ-025 SHALL drive im_data_o=0 and im_addr_o=0 whenever im_we_o=0.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge, put the block in IDLE with count_o=0, im_we_o=0, im_data_o=0, im_addr_o=0, full_o=0, done_o=0, and req_ready_o=1 from the following cycle.
REQ-027 SHALL give rst_i priority over clear_i and requests; a reset during WRITE aborts the write (im_we_o=0 next cycle).

Structure
REQ-028 SHALL take the following from a shared package: opcode constants (R=0, BEQ=4, ADDI=8, SLTI=10), class encoding, state enum, depth constant 32.
REQ-029 SHALL place the field packing in one combinational sub-module instr_word_pack (class + fields -> 32-bit word), which is reusable by the testbench model.
REQ-030 SHALL share its opcode constants with the main control decoder, so that encoding and decoding cannot diverge.

Verification
REQ-031 SHALL cover: after reset, an R-type request rs=1 rt=2 rd=3 funct=0x20 -> next cycle im_we_o=1, addr 0x0, data 0x00221820, count_o=1.
REQ-032 SHALL cover: an addi request rs=8 rt=9 imm=5, then beq rs=1 rt=2 imm=0xFFFF -> data 0x21090005 @0x0, then 0x1022FFFF @0x4.
REQ-033 SHALL cover: an slti request rs=1 rt=2 imm=7 with last_i=1 -> data 0x28220007, then done_o=1, req_ready_o=0, with further valid requests ignored.
REQ-034 SHALL cover: 32 back-to-back requests -> last write @0x7C, then full_o=1, count_o=32, and the 33rd request not accepted.
REQ-035 SHALL cover: clear_i asserted during WRITE of word 5 -> that write still occurs @0x14, then count_o=0, and the next request writes @0x0.
REQ-036 SHALL cover: rst_i asserted in the acceptance cycle -> no im_we_o pulse, IDLE, and count_o=0.
